// File: rtl/fetch_seq_if.sv
// Instruction-memory fetch bus between the sequencer and the instruction store.
// The sequencer drives request/address; the memory returns a byte plus a valid strobe.
interface fetch_seq_if;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic [7:0]  imem_data;
   logic        imem_valid;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_data,
      input  imem_valid
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_data,
      output imem_valid
   );
endinterface

// File: rtl/fetch_seq.sv
// Fetch/execute sequencer: fetches one instruction byte, then commits it in one
// (EXEC0) or two (EXEC0 + EXEC1, waiting on data memory) states.
module fetch_seq (
   input  logic               clk,
   input  logic               rst_n,
   fetch_seq_if.master        imem,
   input  logic               mem_ready,
   input  logic               MC,
   input  logic               J,
   input  logic               LJ,
   input  logic               LJR,
   input  logic               WC,
   input  logic               alu_carry,
   input  logic [15:0]        jaddr,
   output logic [7:0]         inst,
   output logic               cycle,
   output logic               carry,
   output logic [15:0]        link,
   output logic [15:0]        pc
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      EXEC0 = 2'd1,
      EXEC1 = 2'd2
   } state_t;

   state_t      r_state;
   logic [15:0] r_pc;
   logic [7:0]  r_inst;
   logic        r_carry;
   logic [15:0] r_link;
   logic        r_cycle;
   logic        r_imemReq;

   logic [15:0] w_pcInc;

   // The increment silently wraps at 16 bits; no overflow flag is kept.
   assign w_pcInc = r_pc + 16'd1;

   // imem_req and cycle are registered alongside the state so they always
   // reflect the state being entered, including the reset state (FETCH).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= FETCH;
         r_pc      <= 16'h0000;
         r_inst    <= 8'h00;
         r_carry   <= 1'b0;
         r_link    <= 16'h0000;
         r_cycle   <= 1'b0;
         r_imemReq <= 1'b1;
      end else begin
         case (r_state)
            FETCH: begin
               if (imem.imem_valid) begin
                  r_inst    <= imem.imem_data;
                  r_pc      <= w_pcInc;
                  r_state   <= EXEC0;
                  r_imemReq <= 1'b0;
                  r_cycle   <= 1'b0;
               end
            end

            EXEC0: begin
               if (MC) begin
                  r_state <= EXEC1;
                  r_cycle <= 1'b1;
               end else begin
                  if (WC) begin
                     r_carry <= alu_carry;
                  end
                  // pc already points at the next instruction, which is the return address.
                  if (LJ) begin
                     r_pc <= jaddr;
                     if (LJR) begin
                        r_link <= r_pc;
                     end
                  end
                  r_state   <= FETCH;
                  r_imemReq <= 1'b1;
                  r_cycle   <= 1'b0;
               end
            end

            EXEC1: begin
               if (mem_ready) begin
                  if (J) begin
                     r_pc <= jaddr;
                  end
                  if (WC) begin
                     r_carry <= alu_carry;
                  end
                  r_state   <= FETCH;
                  r_imemReq <= 1'b1;
                  r_cycle   <= 1'b0;
               end
            end

            default: begin
               r_state   <= FETCH;
               r_imemReq <= 1'b1;
               r_cycle   <= 1'b0;
            end
         endcase
      end
   end

   assign imem.imem_req  = r_imemReq;
   assign imem.imem_addr = r_pc;
   assign inst           = r_inst;
   assign cycle          = r_cycle;
   assign carry          = r_carry;
   assign link           = r_link;
   assign pc             = r_pc;

endmodule
